// File: rtl/mcdt_demux_if.sv
`default_nettype none
// ============================================================================
//  Module   : mcdt_demux_if
//  Purpose  : Bundle of the MCDT merged input and the three per-channel
//             valid/ready output streams of mcdt_demux.
//             Optional ports guarded by MCDT_DEMUX_STAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
interface mcdt_demux_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
);
    logic [DW-1:0] mcdt_data_i;
    logic          mcdt_val_i;
    logic [1:0]    mcdt_id_i;

    logic [DW-1:0] ch0_data_o,  ch1_data_o,  ch2_data_o;
    logic          ch0_valid_o, ch1_valid_o, ch2_valid_o;
    logic          ch0_ready_i, ch1_ready_i, ch2_ready_i;
    logic [LW-1:0] ch0_level_o, ch1_level_o, ch2_level_o;
    logic [2:0]    ovf_o;
    logic          err_id_o;
`ifdef MCDT_DEMUX_STAT_EN
    logic [15:0]   ch0_cnt_o, ch1_cnt_o, ch2_cnt_o;
`endif

    modport slave (
        input  mcdt_data_i, mcdt_val_i, mcdt_id_i,
        input  ch0_ready_i, ch1_ready_i, ch2_ready_i,
        output ch0_data_o,  ch1_data_o,  ch2_data_o,
        output ch0_valid_o, ch1_valid_o, ch2_valid_o,
        output ch0_level_o, ch1_level_o, ch2_level_o,
`ifdef MCDT_DEMUX_STAT_EN
        output ch0_cnt_o,   ch1_cnt_o,   ch2_cnt_o,
`endif
        output ovf_o, err_id_o
    );

    modport master (
        output mcdt_data_i, mcdt_val_i, mcdt_id_i,
        output ch0_ready_i, ch1_ready_i, ch2_ready_i,
        input  ch0_data_o,  ch1_data_o,  ch2_data_o,
        input  ch0_valid_o, ch1_valid_o, ch2_valid_o,
        input  ch0_level_o, ch1_level_o, ch2_level_o,
`ifdef MCDT_DEMUX_STAT_EN
        input  ch0_cnt_o,   ch1_cnt_o,   ch2_cnt_o,
`endif
        input  ovf_o, err_id_o
    );
endinterface
`default_nettype wire

// File: rtl/mcdt_demux.sv
`default_nettype none
// ============================================================================
//  Module   : mcdt_demux
//  Purpose  : Splits the merged MCDT stream into three FWFT channel FIFOs with
//             sticky overflow / illegal-ID flags. MCDT_DEMUX_STAT_EN adds
//             per-channel 16-bit accepted-word counters.
//  Revision : 1.0  initial release
// ============================================================================
module mcdt_demux #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mcdt_demux_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] w_data  [3];
    logic [LW-1:0] w_level [3];
    logic [2:0]    w_valid;
    logic [2:0]    w_ready;
    logic [2:0]    w_ovf_set;
`ifdef MCDT_DEMUX_STAT_EN
    logic [15:0]   w_cnt   [3];
`endif

    logic [2:0]    ovf_q;
    logic          err_q;

    assign w_ready = {bus.ch2_ready_i, bus.ch1_ready_i, bus.ch0_ready_i};

    for (genvar n = 0; n < 3; n++) begin : g_ch
        logic [DW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [LW-1:0] lvl_q, lvl_d;
        logic          push, pop, full, accept;

        // A full FIFO still takes a write when the head leaves in the same cycle.
        always_comb begin
            push   = bus.mcdt_val_i && (bus.mcdt_id_i == 2'(n));
            pop    = (lvl_q != '0) && w_ready[n];
            full   = (lvl_q == LW'(DEPTH));
            accept = push && (!full || pop);
            wr_d   = accept ? wr_q + AW'(1) : wr_q;
            rd_d   = pop    ? rd_q + AW'(1) : rd_q;
            lvl_d  = lvl_q;
            if (accept && !pop)
                lvl_d = lvl_q + LW'(1);
            else if (pop && !accept)
                lvl_d = lvl_q - LW'(1);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                lvl_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                lvl_q <= lvl_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (accept && !rst_i)
                mem_q[wr_q] <= bus.mcdt_data_i;
        end

        assign w_ovf_set[n] = push && full && !pop;
        assign w_valid[n]   = (lvl_q != '0);
        assign w_data[n]    = w_valid[n] ? mem_q[rd_q] : '0;
        assign w_level[n]   = lvl_q;

`ifdef MCDT_DEMUX_STAT_EN
        logic [15:0] cnt_q;
        always_ff @(posedge clk_i) begin
            if (rst_i)
                cnt_q <= '0;
            else if (accept)
                cnt_q <= cnt_q + 16'd1;
        end
        assign w_cnt[n] = cnt_q;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= '0;
            err_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | w_ovf_set;
            err_q <= err_q | (bus.mcdt_val_i && (bus.mcdt_id_i == 2'd3));
        end
    end

    assign bus.ch0_data_o  = w_data[0];
    assign bus.ch1_data_o  = w_data[1];
    assign bus.ch2_data_o  = w_data[2];
    assign bus.ch0_valid_o = w_valid[0];
    assign bus.ch1_valid_o = w_valid[1];
    assign bus.ch2_valid_o = w_valid[2];
    assign bus.ch0_level_o = w_level[0];
    assign bus.ch1_level_o = w_level[1];
    assign bus.ch2_level_o = w_level[2];
    assign bus.ovf_o       = ovf_q;
    assign bus.err_id_o    = err_q;
`ifdef MCDT_DEMUX_STAT_EN
    assign bus.ch0_cnt_o   = w_cnt[0];
    assign bus.ch1_cnt_o   = w_cnt[1];
    assign bus.ch2_cnt_o   = w_cnt[2];
`endif
endmodule
`default_nettype wire

// File: tb/tb_mcdt_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcdt_demux
//  Purpose  : Self-checking bench for mcdt_demux: queue-based reference model,
//             directed scenarios and a randomized soak.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcdt_demux;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mcdt_demux_if #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) bus ();

    mcdt_demux #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [2:0] ready_v = 3'b000;
    assign bus.ch0_ready_i = ready_v[0];
    assign bus.ch1_ready_i = ready_v[1];
    assign bus.ch2_ready_i = ready_v[2];

    logic [DW-1:0] d_data  [3];
    logic [LW-1:0] d_level [3];
    logic [2:0]    d_valid;
    assign d_data[0]  = bus.ch0_data_o;
    assign d_data[1]  = bus.ch1_data_o;
    assign d_data[2]  = bus.ch2_data_o;
    assign d_level[0] = bus.ch0_level_o;
    assign d_level[1] = bus.ch1_level_o;
    assign d_level[2] = bus.ch2_level_o;
    assign d_valid    = {bus.ch2_valid_o, bus.ch1_valid_o, bus.ch0_valid_o};
`ifdef MCDT_DEMUX_STAT_EN
    logic [15:0] d_cnt [3];
    assign d_cnt[0] = bus.ch0_cnt_o;
    assign d_cnt[1] = bus.ch1_cnt_o;
    assign d_cnt[2] = bus.ch2_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int ch,
                         input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d @%0t: got %0h expected %0h", name, ch, $time, act, exp);
        end
    endtask

    // Reference model: one queue per channel, words leave from the front.
    logic [DW-1:0] mq [3][$];
    logic [2:0]    m_ovf = '0;
    logic          m_err = 1'b0;
    logic [15:0]   m_cnt [3] = '{16'd0, 16'd0, 16'd0};

    always @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                mq[n].delete();
                m_cnt[n] = 16'd0;
            end
            m_ovf = '0;
            m_err = 1'b0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (mq[n].size() > 0 && ready_v[n])
                    void'(mq[n].pop_front());
                if (bus.mcdt_val_i && bus.mcdt_id_i == 2'(n)) begin
                    if (mq[n].size() == DEPTH) begin
                        m_ovf[n] = 1'b1;
                    end else begin
                        mq[n].push_back(bus.mcdt_data_i);
                        m_cnt[n] = m_cnt[n] + 16'd1;
                    end
                end
            end
            if (bus.mcdt_val_i && bus.mcdt_id_i == 2'd3)
                m_err = 1'b1;
        end
    end

    bit check_en = 1'b0;
    always @(negedge clk) begin
        if (check_en) begin
            for (int n = 0; n < 3; n++) begin
                check("valid", n, 64'(d_valid[n]), 64'(mq[n].size() != 0));
                check("data",  n, 64'(d_data[n]),  mq[n].size() != 0 ? 64'(mq[n][0]) : 64'd0);
                check("level", n, 64'(d_level[n]), 64'(mq[n].size()));
`ifdef MCDT_DEMUX_STAT_EN
                check("cnt",   n, 64'(d_cnt[n]),   64'(m_cnt[n]));
`endif
            end
            check("ovf", -1, 64'(bus.ovf_o),    64'(m_ovf));
            check("err", -1, 64'(bus.err_id_o), 64'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [1:0] id, input logic [DW-1:0] d);
        bus.mcdt_val_i  = v;
        bus.mcdt_id_i   = id;
        bus.mcdt_data_i = d;
    endtask

    initial begin
        beat(1'b1, 2'd0, 32'h1111_0000);

        // Beats offered throughout reset must all be lost.
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 2'($urandom_range(0, 3)), $urandom);
            step();
            check_en = 1'b1;
        end
        check("rst_valid", -1, 64'(d_valid), 64'd0);
        check("rst_level", 1, 64'(d_level[1]), 64'd0);
        check("rst_flags", -1, {60'd0, bus.ovf_o, bus.err_id_o}, 64'd0);

        rst = 1'b0;
        beat(1'b1, 2'd0, 32'h0000_00A5);
        step();
        check("first_valid", 0, 64'(d_valid[0]), 64'd1);
        check("first_data",  0, 64'(d_data[0]),  64'h0000_00A5);
        beat(1'b0, 2'd0, '0);
        ready_v = 3'b001;
        step();

        // ch0: 100 beats, one every other cycle, consumer always ready.
        for (int i = 0; i < 100; i++) begin
            beat(1'b1, 2'd0, 32'h00C0_0000 + DW'(i));
            step();
            check("ch0_lvl_le1", 0, 64'(d_level[0] <= 1), 64'd1);
            beat(1'b0, 2'd0, '0);
            step();
        end
        check("ch0_ovf", -1, 64'(bus.ovf_o), 64'd0);

        // ch1: 10 back-to-back beats into a stalled consumer.
        ready_v = 3'b000;
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 2'd1, 32'h00C1_0000 + DW'(i));
            step();
        end
        beat(1'b0, 2'd0, '0);
        check("ch1_full_lvl", 1, 64'(d_level[1]), 64'd8);
        check("ch1_ovf",     -1, 64'(bus.ovf_o),  64'b010);
        check("ch1_head",     1, 64'(d_data[1]),  64'h00C1_0000);
`ifdef MCDT_DEMUX_STAT_EN
        check("ch1_cnt",      1, 64'(d_cnt[1]),   64'd8);
`endif
        ready_v = 3'b010;
        for (int i = 0; i < 10; i++) step();
        check("ch1_drained", 1, 64'(d_level[1]), 64'd0);

        // ch2: fill, then push while popping at full.
        ready_v = 3'b000;
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 2'd2, 32'h00C2_0000 + DW'(i));
            step();
        end
        beat(1'b1, 2'd2, 32'h00C2_0008);
        ready_v = 3'b100;
        step();
        beat(1'b0, 2'd0, '0);
        ready_v = 3'b000;
        check("ch2_full_lvl", 2, 64'(d_level[2]), 64'd8);
        check("ch2_ovf",     -1, 64'(bus.ovf_o),  64'b010);
        check("ch2_head",     2, 64'(d_data[2]),  64'h00C2_0001);
        ready_v = 3'b100;
        for (int i = 0; i < 9; i++) step();

        // Interleaved ids with all consumers ready: one-cycle latency.
        ready_v = 3'b111;
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 2'(i % 3), 32'h00D0_0000 + DW'(i));
            step();
            check("il_valid", i % 3, 64'(d_valid[i % 3]), 64'd1);
            check("il_data",  i % 3, 64'(d_data[i % 3]),  64'h00D0_0000 + 64'(i));
        end
        beat(1'b0, 2'd0, '0);
        step();
        beat(1'b1, 2'd3, 32'hDEAD_BEEF);
        step();
        beat(1'b0, 2'd0, '0);
        check("err_id", -1, 64'(bus.err_id_o), 64'd1);
        check("err_lvls", -1, {40'd0, 8'(d_level[0]), 8'(d_level[1]), 8'(d_level[2])}, 64'd0);

        // Randomized soak with shifting consumer stall rates and one mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            int pct;
            pct = 20 + 30 * ((i / 250) % 3);
            beat($urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 49) == 0) bus.mcdt_id_i = 2'd3;
            else if (bus.mcdt_id_i == 2'd3) bus.mcdt_id_i = 2'd1;
            for (int n = 0; n < 3; n++)
                ready_v[n] = ($urandom_range(0, 99) < pct);
            rst = (i == 1500 || i == 1501);
            step();
        end
        rst = 1'b0;
        beat(1'b0, 2'd0, '0);
        ready_v = 3'b111;
        for (int i = 0; i < 10; i++) step();
        check("final_empty", -1, 64'(d_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mcdt_demux.md
# mcdt_demux

Receive-side demultiplexer that sits on the MCDT output port and splits the merged stream back into three per-channel streams. Each word on `mcdt_data_i` is steered by `mcdt_id_i` into one of three per-channel FIFOs, and each FIFO is drained through a valid/ready handshake. The MCDT output has no backpressure, so overflow and illegal-ID events are dropped and flagged.

## Interface

Parameters:

- `DW`, 32, data width; equals the MCDT data width.
- `DEPTH`, 8, entries per channel FIFO; power of two, ≥ 2.
- `LW`, `$clog2(DEPTH)+1`, width of the level outputs.

Ports:

- `clk_i`  input  1  single clock.
- `rst_i`  input  1  reset; synchronous, active-high.
- `mcdt_data_i`  input  DW  merged data from MCDT.
- `mcdt_val_i`  input  1  merged data valid; there is no ready back to MCDT.
- `mcdt_id_i`  input  2  source channel; legal values are 0–2.
- `chN_data_o` (N = 0,1,2)  output  DW  head-of-FIFO data; 0 when the FIFO is empty.
- `chN_valid_o`  output  1  FIFO N is non-empty.
- `chN_ready_i`  input  1  consumer of channel N accepts the head word.
- `chN_level_o`  output  LW  occupancy of FIFO N, 0..DEPTH.
- `ovf_o`  output  3  sticky per-channel overflow flags.
- `err_id_o`  output  1  sticky flag: a beat arrived with `mcdt_id_i` = 3.

## Operation

- Write: when `mcdt_val_i` = 1 and `mcdt_id_i` = N (N = 0..2), the word is pushed into FIFO N.
- Pop: when `chN_valid_o` and `chN_ready_i` are both 1 at a rising edge, the head of FIFO N is removed.
- FIFOs are first-word-fall-through. Each one uses a write pointer and a read pointer of `$clog2(DEPTH)` bits, wrapping from DEPTH-1 to 0, plus a separate counter for `chN_level_o`.
- Full FIFO:
  - A write with a simultaneous pop on the same channel is accepted; the level stays at DEPTH.
  - A write without a pop is dropped, no FIFO state changes, and `ovf_o[N]` is set.
- Empty FIFO: `chN_ready_i` is ignored; there is no underflow and the pointers do not move.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the level is unchanged.
- Illegal ID (`mcdt_id_i` = 3 with `mcdt_val_i` = 1): the beat is dropped and `err_id_o` is set.
- Sticky flags clear only on reset.
- Channels are fully independent; one channel stalling never affects the others.
- Word order within each channel is preserved exactly.

## Timing

- All state updates on the rising edge of `clk_i`.
- Reset is checked before any other update. While `rst_i` = 1 at an edge:
  - all pointers and levels go to 0;
  - `chN_valid_o` = 0, `chN_data_o` = 0, `chN_level_o` = 0;
  - `ovf_o` = 0, `err_id_o` = 0;
  - the FIFO RAM contents are don't-care.
- Reset applied mid-stream discards all buffered words. Any beat presented in the reset cycle is lost.
- Latency: a beat accepted at edge k gives `chN_valid_o` = 1 and the word on `chN_data_o` after edge k. There is no combinational path from `mcdt_*` to the outputs.
- `chN_level_o`, `ovf_o` and `err_id_o` reflect the state after edge k.
- A pop at edge k presents the next word (or valid = 0) after edge k.
- `chN_valid_o` does not depend combinationally on `chN_ready_i`.
- Maximum throughput is one write per cycle into any channel and one pop per cycle per channel.

## Configuration

- Macro: `MCDT_DEMUX_STAT_EN`.
- With the macro defined, three extra outputs exist:
  - `chN_cnt_o` (16 bits each) counts words accepted into FIFO N;
  - the counters wrap 0xFFFF → 0x0000;
  - dropped overflow beats are not counted;
  - the counters reset to 0.
- Without the macro, the ports and counters are absent and all other behaviour is identical.

## Test plan

- Hold reset for 10 cycles with `mcdt_val_i` = 1 → all outputs stay 0. Release reset → the first beat after release is accepted.
- Send ch0 words 0x00C0_0000..0x00C0_0063 (100 beats), one every two cycles, with `ch0_ready_i` held at 1 → 100 words pop in order, `ch0_level_o` ≤ 1, and `ovf_o` = 0.
- `ch1_ready_i` = 0; send 10 back-to-back beats on id 1 with data 0x00C1_0000+i, DEPTH = 8 →
  - `ch1_level_o` = 8 and `ovf_o` = 3'b010;
  - draining yields 0x00C1_0000..0x00C1_0007 only.
- Channel 2 full; push 0x00C2_0008 with `ch2_ready_i` = 1 in the same cycle → the pop and the push both happen, level stays 8, and `ovf_o[2]` stays 0.
- Interleave ids 0,1,2,0,1,2 with consumers ready → each channel receives its words in order with a latency of one cycle. Then one beat with id 3 → `err_id_o` = 1 and all levels are unchanged.
- With `MCDT_DEMUX_STAT_EN` defined, repeat the overflow case → `ch1_cnt_o` = 8, not 10.
